// File: rtl/display_pkg.sv
// Shared types and constants for the display SPI arbiter: FSM states,
// one-hot grant encodings and default chip-select timings.
package display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CFG  = 2'b01;
  localparam logic [1:0] GRANT_PX   = 2'b10;

  localparam int DEFAULT_CS_SETUP_CYCLES = 1;
  localparam int DEFAULT_CS_GAP_CYCLES   = 2;

  // The counter is loaded on the edge that enters the timed state, so a
  // duration of N cycles needs a load value of N-1.
  function automatic logic [3:0] cycles_to_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/delay_counter.sv
// Loadable 4-bit down-counter; done is high whenever the count sits at zero.
module delay_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/display_spi_arbiter.sv
// Arbitrates a config and a pixel byte stream onto one SPI byte transmitter,
// framing each transaction with display chip select and the D/C line.
//
// Handshake: a byte moves on any edge where valid && ready are both high;
// valid must not depend on ready, and data/dc/last hold while valid is high
// and ready is low.
module display_spi_arbiter
  import display_pkg::*;
#(
  parameter int CS_SETUP_CYCLES = DEFAULT_CS_SETUP_CYCLES,
  parameter int CS_GAP_CYCLES   = DEFAULT_CS_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  input  logic       cfg_dc,
  input  logic       cfg_last,
  output logic       cfg_ready,
  input  logic       px_valid,
  input  logic [7:0] px_data,
  input  logic       px_dc,
  input  logic       px_last,
  output logic       px_ready,
  output logic       spi_valid,
  output logic [7:0] spi_data,
  input  logic       spi_ready,
  input  logic       spi_busy,
  output logic       display_csb,
  output logic       data_commandb,
  output logic [1:0] grant,
  output logic       busy,
  output logic [2:0] state_dbg
);

  state_t     state;
  state_t     state_next;
  logic [1:0] grant_q;
  logic [1:0] pick;
  logic       csb_q;
  logic       dc_q;
  logic       last_was_cfg;
  logic       owner_valid;
  logic [7:0] owner_data;
  logic       owner_dc;
  logic       owner_last;
  logic       any_req;
  logic       accept;
  logic       drain_done;
  logic       timer_load;
  logic [3:0] timer_value;
  logic       timer_done;

  assign any_req    = cfg_valid | px_valid;
  assign accept     = (state == ST_XFER) && owner_valid && spi_ready;
  assign drain_done = (state == ST_DRAIN) && !spi_busy && spi_ready;

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = 8'h00;
    owner_dc    = 1'b0;
    owner_last  = 1'b0;
    if (grant_q == GRANT_CFG) begin
      owner_valid = cfg_valid;
      owner_data  = cfg_data;
      owner_dc    = cfg_dc;
      owner_last  = cfg_last;
    end else if (grant_q == GRANT_PX) begin
      owner_valid = px_valid;
      owner_data  = px_data;
      owner_dc    = px_dc;
      owner_last  = px_last;
    end
  end

  // On a tie the requester that did not own the last completed transaction wins.
  always_comb begin
    pick = GRANT_NONE;
    if (cfg_valid && px_valid) begin
      pick = last_was_cfg ? GRANT_PX : GRANT_CFG;
    end else if (cfg_valid) begin
      pick = GRANT_CFG;
    end else if (px_valid) begin
      pick = GRANT_PX;
    end
  end

  assign timer_load  = ((state == ST_IDLE) && any_req) || drain_done;
  assign timer_value = (state == ST_IDLE) ? cycles_to_load(CS_SETUP_CYCLES)
                                          : cycles_to_load(CS_GAP_CYCLES);

  delay_counter u_delay_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_req) state_next = ST_SETUP;
      ST_SETUP: if (timer_done) state_next = ST_XFER;
      ST_XFER:  if (accept && owner_last) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_GAP;
      ST_GAP:   if (timer_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_valid = 1'b0;
    spi_data  = 8'h00;
    cfg_ready = 1'b0;
    px_ready  = 1'b0;
    if (state == ST_XFER) begin
      spi_valid = owner_valid;
      spi_data  = owner_data;
      cfg_ready = grant_q[0] & spi_ready;
      px_ready  = grant_q[1] & spi_ready;
    end
  end

  // Grant, chip select and D/C are registered alongside the state so they
  // change on the same edges as the transitions that own them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= GRANT_NONE;
      csb_q        <= 1'b1;
      dc_q         <= 1'b1;
      last_was_cfg <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && any_req) begin
        grant_q <= pick;
        csb_q   <= 1'b0;
      end
      if (drain_done) begin
        grant_q      <= GRANT_NONE;
        csb_q        <= 1'b1;
        last_was_cfg <= grant_q[0];
      end
      if (accept) begin
        dc_q <= owner_dc;
      end
    end
  end

  assign display_csb   = csb_q;
  assign data_commandb = dc_q;
  assign grant         = grant_q;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: doc/display_spi_arbiter.md
DISPLAY_SPI_ARBITER -- requirements
Module: display_spi_arbiter

Interface
REQ-001 Parameters SHALL be: CS_SETUP_CYCLES, default 1, csb-low cycles before the first byte (legal range 1..15); CS_GAP_CYCLES, default 2, csb-high cycles between transactions (legal range 1..15).
REQ-002 clk  in  1  system clock, 12 MHz; sole clock domain.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cfg_valid/cfg_data/cfg_dc/cfg_last  in  1/8/1/1  config requester byte stream; dc=0 command, 1 data; last marks final byte.
REQ-005 cfg_ready  out  1  config byte accepted when cfg_valid&&cfg_ready.
REQ-006 px_valid/px_data/px_dc/px_last  in  1/8/1/1  pixel requester byte stream; same encoding.
REQ-007 px_ready  out  1  pixel byte accepted when px_valid&&px_ready.
REQ-008 spi_valid/spi_data  out  1/8  byte offered to SPI byte transmitter.
REQ-009 spi_ready  in  1  transmitter can accept a byte this cycle.
REQ-010 spi_busy  in  1  transmitter is still shifting a byte.
REQ-011 display_csb  out  1  display chip select, active-low.
REQ-012 data_commandb  out  1  display D/C line.
REQ-013 grant  out  2  one-hot owner: [0]=cfg, [1]=px; 00 when none.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, XFER, DRAIN, GAP.
REQ-016 IDLE: if any requester has valid=1, SHALL register grant and csb=0 on the next edge and enter SETUP.
REQ-017 Arbitration: single request wins; on simultaneous requests cfg wins unless the previous completed transaction was cfg, in which case px wins (alternation).
REQ-018 SETUP SHALL last exactly CS_SETUP_CYCLES cycles, then enter XFER; all ready outputs 0 in SETUP.
REQ-019 XFER: spi_valid=owner valid, spi_data=owner data (combinational); owner ready=spi_ready; non-owner ready=0 at all times.
REQ-020 data_commandb SHALL be registered from owner dc at each accepted byte and held until the next accepted byte.
REQ-021 Owner valid low during XFER SHALL hold XFER with csb=0 indefinitely (no timeout).
REQ-022 Acceptance of a byte with last=1 SHALL enter DRAIN; no further bytes accepted.
REQ-023 DRAIN SHALL exit when spi_busy=0 and spi_ready=1, setting csb=1 and grant=00 on that edge, entering GAP.
REQ-024 GAP SHALL last exactly CS_GAP_CYCLES cycles, then IDLE; requests during GAP wait.
REQ-025 A single-byte transaction (first byte has last=1) SHALL go XFER->DRAIN after one accepted byte.
REQ-026 Minimum idle-request-to-first-accept latency SHALL be 1+CS_SETUP_CYCLES cycles.

Reset
REQ-027 While rst=1 SHALL force, asynchronously: state IDLE, display_csb=1, data_commandb=1, grant=00, busy=0, spi_valid=0, cfg_ready=0, px_ready=0, last-owner=px (so cfg wins the first tie).
REQ-028 rst mid-transaction SHALL raise csb immediately and drop the transaction; no resume after release.

Structure
REQ-029 State enum, grant encoding constants and default CS timings SHALL live in shared package display_pkg.
REQ-030 SETUP/GAP timing SHALL use one sub-module, delay_counter (loadable 4-bit down-counter with done flag).

Verification
REQ-031 cfg-only: cmd 0x2A (dc=0) then data 0x00,0xEF (last) -> csb falls 1 cycle after valid, first accept 2 cycles after valid, D/C 0,1,1, csb rises after spi_busy falls, 2 gap cycles.
REQ-032 Simultaneous cfg+px after reset -> cfg granted first; px granted after GAP; grant never 11.
REQ-033 Continuous cfg+px streams, 3-byte transactions -> grants alternate cfg,px,cfg,px; each csb-high gap exactly 2 cycles.
REQ-034 spi_ready stalled low 5 cycles mid-XFER, then owner valid dropped 3 cycles -> no byte lost or duplicated, csb stays 0, D/C stable.
REQ-035 rst asserted in XFER with byte 0x55 pending -> csb=1, ready=0, grant=00 same cycle; after release, new request starts a fresh SETUP.
